// File: rtl/frame_scheduler_if.sv
// Frame scheduler signal bundle: deserializer side, encoder side and statistics.
// master drives the token stream and controls; slave is the scheduler itself.
interface frame_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             valid;
    logic [9:0]       tkn;
    logic             enable;
    logic             fifo_afull;
    logic             pvalid;
    logic             vsync;
    logic             frame_start;
    logic [CNT_W-1:0] frames_sent;
    logic [CNT_W-1:0] frames_dropped;

    modport master (
        output valid, tkn, enable, fifo_afull,
        input  pvalid, vsync, frame_start, frames_sent, frames_dropped
    );

    modport slave (
        input  valid, tkn, enable, fifo_afull,
        output pvalid, vsync, frame_start, frames_sent, frames_dropped
    );
endinterface

// File: rtl/frame_scheduler.sv
// TMDS channel-0 token decoder and frame gate feeding the MJPG encoder.
// Define FRAME_SCHED_STATS_EN to build the frames_sent/frames_dropped counters.
module frame_scheduler #(
    parameter int DIV   = 2,
    parameter int DELAY = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    frame_scheduler_if.slave  bus
);
    localparam logic [9:0] CTL0   = 10'b1101010100;
    localparam logic [9:0] CTL1   = 10'b0010101011;
    localparam logic [9:0] CTL2   = 10'b0101010100;
    localparam logic [9:0] CTL3   = 10'b1010101011;
    localparam logic [9:0] START0 = 10'b1011001100;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(DELAY + 1);

    typedef enum logic [1:0] {IDLE, PASS, SKIP} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [1:0]      r_sh;
    logic            r_px;
    logic            r_vs;
    logic [DW-1:0]   r_dcnt;
    logic [DELAY-1:0] r_pv_sr;
    logic [DELAY-1:0] r_vs_sr;
    logic [RW-1:0]   r_rcnt;
    logic            r_vsync_q;

    logic w_vd;
    logic w_va;
    logic w_ctl;
    logic w_st;
    logic w_fe;
    logic w_sel;
    logic w_go;
    logic w_gate;
    logic w_oen;
    logic w_pvalid;
    logic w_vsync;

    assign w_vd   = (bus.tkn == CTL0) | (bus.tkn == CTL1);
    assign w_va   = (bus.tkn == CTL2) | (bus.tkn == CTL3);
    assign w_ctl  = w_vd | w_va;
    assign w_st   = (bus.tkn == START0);
    assign w_fe   = bus.valid & ~r_vs & w_va;
    assign w_sel  = bus.enable & (r_dcnt == '0);
    assign w_go   = w_sel & ~bus.fifo_afull;
    assign w_gate = (r_state == PASS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
            r_px <= 1'b0;
            r_vs <= 1'b0;
        end else if (!bus.valid) begin
            r_sh <= '0;
            r_px <= 1'b0;
            r_vs <= 1'b0;
        end else begin
            r_sh <= {r_sh[0], w_st};
            // control tokens end active video even if a guard band coincides
            r_px <= w_ctl ? 1'b0 : ((&r_sh) ? 1'b1 : r_px);
            r_vs <= w_vd ? 1'b0 : (w_va ? 1'b1 : r_vs);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dcnt <= '0;
        end else if (w_fe) begin
            r_dcnt <= (r_dcnt == DW'(DIV - 1)) ? '0 : r_dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (!bus.valid) begin
            w_state_nx = IDLE;
        end else if (w_fe) begin
            w_state_nx = w_go ? PASS : SKIP;
        end
    end

    // alignment pipe carries stale data after reset; r_rcnt masks it out
    always_ff @(posedge clk) begin
        r_pv_sr[0] <= r_px & w_gate;
        r_vs_sr[0] <= r_vs & w_gate;
        for (int i = 1; i < DELAY; i++) begin
            r_pv_sr[i] <= r_pv_sr[i-1];
            r_vs_sr[i] <= r_vs_sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt <= '0;
        end else if (r_rcnt != RW'(DELAY)) begin
            r_rcnt <= r_rcnt + 1'b1;
        end
    end

    assign w_oen    = (r_rcnt == RW'(DELAY)) & ~rst;
    assign w_pvalid = r_pv_sr[DELAY-1] & w_oen;
    assign w_vsync  = r_vs_sr[DELAY-1] & w_oen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_q <= 1'b0;
        end else begin
            r_vsync_q <= w_vsync;
        end
    end

    assign bus.pvalid      = w_pvalid;
    assign bus.vsync       = w_vsync;
    assign bus.frame_start = w_vsync & ~r_vsync_q;

`ifdef FRAME_SCHED_STATS_EN
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_drop;
    logic             w_sent_inc;
    logic             w_drop_inc;

    assign w_sent_inc = w_fe & w_go;
    assign w_drop_inc = (w_fe & w_sel & bus.fifo_afull)
                      | (~bus.valid & w_gate);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sent <= '0;
            r_drop <= '0;
        end else begin
            if (w_sent_inc && (r_sent != '1)) begin
                r_sent <= r_sent + 1'b1;
            end
            if (w_drop_inc && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign bus.frames_sent    = r_sent;
    assign bus.frames_dropped = r_drop;
`else
    assign bus.frames_sent    = '0;
    assign bus.frames_dropped = '0;
`endif
endmodule

// File: tb/tb_frame_scheduler.sv
// Randomized frame streams checked against a frame-level reference model.
// Includes directed latency, mid-frame reset and counter saturation cases.
module tb_frame_scheduler;
    localparam int DV = 2;
    localparam int DL = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [9:0] CTL0   = 10'b1101010100;
    localparam logic [9:0] CTL1   = 10'b0010101011;
    localparam logic [9:0] CTL2   = 10'b0101010100;
    localparam logic [9:0] CTL3   = 10'b1010101011;
    localparam logic [9:0] START0 = 10'b1011001100;
`ifdef FRAME_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    frame_scheduler_if #(.CNT_W(CW)) bus ();

    frame_scheduler #(
        .DIV(DV), .DELAY(DL), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int n_cyc = 0;
    int rate_afull = 3;
    int rate_drop = 0;

    // reference model: token history, frame decision, output alignment
    bit m_st1, m_st0;
    bit m_px, m_vs;
    bit m_pass;
    int m_dc;
    int m_sent, m_drop;
    int m_rc;
    bit m_vsq;
    bit q_pv[$];
    bit q_vs[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                         tag, n_cyc, got, exp);
        end
    endtask

    function automatic bit is_tok(input logic [9:0] t);
        return t == CTL0 || t == CTL1 || t == CTL2 || t == CTL3
            || t == START0;
    endfunction

    function automatic logic [9:0] pix();
        logic [9:0] t;
        do t = 10'($urandom_range(0, 1023)); while (is_tok(t));
        return t;
    endfunction

    function automatic bit exp_pv();
        return (m_rc == DL) && !rst && q_pv[DL-1];
    endfunction

    function automatic bit exp_vs();
        return (m_rc == DL) && !rst && q_vs[DL-1];
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_edge(input bit v, input logic [9:0] t);
        bit va, vd, ctl, fe, sel, old_vs;
        old_vs = exp_vs();
        q_pv.push_front(m_px && m_pass);
        q_vs.push_front(m_vs && m_pass);
        void'(q_pv.pop_back());
        void'(q_vs.pop_back());
        if (rst) begin
            {m_st1, m_st0, m_px, m_vs, m_pass, m_vsq} = '0;
            m_dc = 0; m_sent = 0; m_drop = 0; m_rc = 0;
            return;
        end
        m_vsq = old_vs;
        if (m_rc < DL) m_rc++;
        if (!v) begin
            if (m_pass) m_drop = sat(m_drop);
            {m_st1, m_st0, m_px, m_vs, m_pass} = '0;
            return;
        end
        va  = (t == CTL2) || (t == CTL3);
        vd  = (t == CTL0) || (t == CTL1);
        ctl = va || vd;
        fe  = !m_vs && va;
        if (fe) begin
            sel = bus.enable && (m_dc == 0);
            if (sel && bus.fifo_afull) m_drop = sat(m_drop);
            if (sel && !bus.fifo_afull) m_sent = sat(m_sent);
            m_pass = sel && !bus.fifo_afull;
            m_dc = (m_dc + 1) % DV;
        end
        if (ctl) m_px = 1'b0;
        else if (m_st1 && m_st0) m_px = 1'b1;
        if (vd) m_vs = 1'b0;
        else if (va) m_vs = 1'b1;
        m_st1 = m_st0;
        m_st0 = (t == START0);
    endtask

    task automatic cyc(input logic [9:0] t);
        bit v;
        v = !((rate_drop != 0) && ($urandom_range(0, 999) < rate_drop));
        if ($urandom_range(0, 99) < rate_afull)
            bus.fifo_afull = !bus.fifo_afull;
        bus.valid = v;
        bus.tkn = v ? t : pix();
        @(posedge clk);
        model_edge(v, bus.tkn);
        @(negedge clk);
        n_cyc++;
        chk("pvalid", 32'(bus.pvalid), 32'(exp_pv()));
        chk("vsync", 32'(bus.vsync), 32'(exp_vs()));
        chk("frame_start", 32'(bus.frame_start),
            32'(exp_vs() && !m_vsq));
        chk("sent", 32'(bus.frames_sent), STATS ? 32'(m_sent) : 32'd0);
        chk("dropped", 32'(bus.frames_dropped),
            STATS ? 32'(m_drop) : 32'd0);
    endtask

    task automatic line(input int w);
        cyc(START0);
        cyc(START0);
        for (int i = 0; i < w; i++) cyc(pix());
        cyc(CTL3);
        cyc(CTL2);
    endtask

    task automatic frame();
        int nl;
        for (int i = 0; i < $urandom_range(2, 5); i++)
            cyc($urandom_range(0, 1) ? CTL0 : CTL1);
        for (int i = 0; i < $urandom_range(2, 3); i++)
            cyc($urandom_range(0, 1) ? CTL2 : CTL3);
        nl = $urandom_range(1, 3);
        for (int l = 0; l < nl; l++) begin
            if ($urandom_range(0, 9) == 0) bus.enable = !bus.enable;
            line($urandom_range(2, 6));
        end
    endtask

    int s_at, rise, fall_at, fall, vs_at, vrise;
    bit prev_pv, prev_vs;

    initial begin
        for (int i = 0; i < DL; i++) begin
            q_pv.push_back(1'b0);
            q_vs.push_back(1'b0);
        end
        bus.valid = 1'b1;
        bus.tkn = CTL0;
        bus.enable = 1'b1;
        bus.fifo_afull = 1'b0;
        rate_afull = 0;
        rst = 1'b1;
        cyc(CTL0);
        cyc(CTL0);
        chk("rst_pvalid", 32'(bus.pvalid), 32'd0);
        chk("rst_vsync", 32'(bus.vsync), 32'd0);
        chk("rst_sent", 32'(bus.frames_sent), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) cyc(CTL0);

        // directed alignment: first selected frame after reset
        rise = -1; vrise = -1; fall = -1;
        vs_at = n_cyc;
        cyc(CTL2);
        cyc(CTL2);
        s_at = n_cyc;
        cyc(START0);
        cyc(START0);
        for (int i = 0; i < 12; i++) begin
            cyc(pix());
            if (bus.pvalid && rise < 0) rise = n_cyc - s_at;
            if (bus.vsync && vrise < 0) vrise = n_cyc - vs_at;
        end
        fall_at = n_cyc;
        for (int i = 0; i < 12; i++) begin
            cyc(CTL0);
            if (!bus.pvalid && fall < 0) fall = n_cyc - fall_at;
        end
        chk("lat_pv_rise", 32'(rise), 32'd11);
        chk("lat_vs_rise", 32'(vrise), 32'(DL + 1));
        chk("lat_pv_fall", 32'(fall), 32'(DL + 1));

        // mid-frame reset: partial frame must stay masked
        frame();
        frame();
        cyc(CTL2);
        line(4);
        cyc(START0);
        cyc(START0);
        cyc(pix());
        rst = 1'b1;
        cyc(pix());
        cyc(pix());
        rst = 1'b0;
        for (int i = 0; i < 4; i++) line(5);

        // randomized traffic with afull, enable toggles and valid loss
        rate_afull = 3;
        rate_drop = 3;
        for (int f = 0; f < 140; f++) begin
            if ($urandom_range(0, 7) == 0) bus.enable = !bus.enable;
            frame();
        end
        rate_drop = 0;
        rate_afull = 0;
        bus.fifo_afull = 1'b0;
        bus.enable = 1'b1;
        for (int f = 0; f < 40; f++) frame();
        chk("sent_sat", 32'(bus.frames_sent), STATS ? CMAX : 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
